// File: rtl/uart_cmd_pkg.sv
// Shared frame constants, FSM state encoding and helpers for the UART servo command parser.
package uart_cmd_pkg;

  localparam logic [7:0] HDR0_BYTE = 8'h55;
  localparam logic [7:0] HDR1_BYTE = 8'hAA;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    ST_H0  = 3'd0,
    ST_H1  = 3'd1,
    ST_ID  = 3'd2,
    ST_HI  = 3'd3,
    ST_LO  = 3'd4,
    ST_CS  = 3'd5,
    ST_OUT = 3'd6,
    ST_ACK = 3'd7
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_byte_timeout.sv
// Inter-byte idle counter: counts cycles while armed, clears on every accepted byte.
// o_expire is combinational and suppressed when a byte arrives in the same cycle.
module byte_timeout #(
  parameter logic [31:0] LIMIT = 32'd50000
) (
  input  logic fpga_clk_50,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);

  logic [31:0] r_cnt;
  logic        w_hit;

  assign w_hit    = (r_cnt == LIMIT - 32'd1);
  assign o_expire = i_run && !i_clear && w_hit;

  always_ff @(posedge fpga_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 32'd0;
    end else if (!i_run || i_clear || w_hit) begin
      r_cnt <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 55 AA ID HI LO CS frames into servo commands, then answers ACK/NAK on the tx side.
// Command appears one cycle after the CS byte; rx is stalled while a command or ACK is pending.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int TIMEOUT_US = 1000,
  parameter int NUM_SERVO  = 6
) (
  input  logic        fpga_clk_50,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_id,
  output logic [15:0] cmd_pos,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] TO_LIMIT = 32'(CLK_FRE * TIMEOUT_US);
  localparam logic [7:0]  NUM_ID   = 8'(NUM_SERVO);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_id;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [2:0]  r_cmd_id;
  logic [15:0] r_cmd_pos;
  logic        r_cmd_valid;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_err;

  logic        w_accept;
  logic        w_in_frame;
  logic        w_timeout;
  logic [7:0]  w_sum;
  logic        w_cs_ok;
  logic        w_err_inc;
  logic        w_load_cmd;
  logic        w_ack_load;
  logic [7:0]  w_ack_byte;

  assign rx_data_ready = (r_state != ST_OUT) && (r_state != ST_ACK);
  assign w_accept      = rx_data_valid && rx_data_ready;
  assign w_in_frame    = r_state inside {ST_H1, ST_ID, ST_HI, ST_LO, ST_CS};
  assign w_sum         = r_id + r_hi + r_lo;
  assign w_cs_ok       = (w_sum == rx_data) && (r_id < NUM_ID);

  byte_timeout #(.LIMIT(TO_LIMIT)) u_byte_timeout (
    .fpga_clk_50 (fpga_clk_50),
    .rst_n       (rst_n),
    .i_run       (w_in_frame),
    .i_clear     (w_accept),
    .o_expire    (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_inc   = 1'b0;
    w_load_cmd  = 1'b0;
    w_ack_load  = 1'b0;
    w_ack_byte  = ACK_BYTE;
    case (r_state)
      ST_H0:  if (w_accept && rx_data == HDR0_BYTE) w_state_nxt = ST_H1;
      ST_H1: begin
        // Repeated 0x55 is treated as a fresh preamble, anything else resyncs quietly.
        if (w_accept) begin
          if (rx_data == HDR1_BYTE)      w_state_nxt = ST_ID;
          else if (rx_data != HDR0_BYTE) w_state_nxt = ST_H0;
        end
      end
      ST_ID:  if (w_accept) w_state_nxt = ST_HI;
      ST_HI:  if (w_accept) w_state_nxt = ST_LO;
      ST_LO:  if (w_accept) w_state_nxt = ST_CS;
      ST_CS: begin
        if (w_accept) begin
          if (w_cs_ok) begin
            w_state_nxt = ST_OUT;
            w_load_cmd  = 1'b1;
          end else begin
            w_state_nxt = ST_ACK;
            w_ack_load  = 1'b1;
            w_ack_byte  = NAK_BYTE;
            w_err_inc   = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (cmd_ready) begin
          w_state_nxt = ST_ACK;
          w_ack_load  = 1'b1;
        end
      end
      ST_ACK: if (tx_data_ready) w_state_nxt = ST_H0;
      default: w_state_nxt = ST_H0;
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_H0;
      w_err_inc   = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_H0;
      r_id        <= 8'd0;
      r_hi        <= 8'd0;
      r_lo        <= 8'd0;
      r_cmd_id    <= 3'd0;
      r_cmd_pos   <= 16'd0;
      r_cmd_valid <= 1'b0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_err       <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        case (r_state)
          ST_ID:   r_id <= rx_data;
          ST_HI:   r_hi <= rx_data;
          ST_LO:   r_lo <= rx_data;
          default: ;
        endcase
      end
      if (w_load_cmd) begin
        r_cmd_id  <= r_id[2:0];
        r_cmd_pos <= {r_hi, r_lo};
      end
      r_cmd_valid <= (w_state_nxt == ST_OUT);
      if (w_ack_load) r_tx_data <= w_ack_byte;
      r_tx_valid  <= (w_state_nxt == ST_ACK);
      if (w_err_inc) r_err <= sat_inc8(r_err);
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_id        = r_cmd_id;
  assign cmd_pos       = r_cmd_pos;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign err_cnt       = r_err;

endmodule
